// File: rtl/nas_vid_capture.sv
// Nascom 2 composite video capture: separates h/v sync by pulse width, samples
// the pixel stream and emits packed frame-buffer byte writes.
module nas_vid_capture #(
    parameter int HSYNC_MIN    = 32,
    parameter int VSYNC_MIN    = 400,
    parameter int H_START      = 160,
    parameter int H_PIXELS     = 384,
    parameter int V_START      = 20,
    parameter int V_LINES      = 224,
    parameter int LINE_TIMEOUT = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_sync,
    input  logic        vid_data,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic        locked,
    output logic        sync_lost,
    output logic [8:0]  line_cnt
);

    localparam int PW = $clog2(H_PIXELS + 1);
    localparam logic [10:0] HS_MIN  = 11'(HSYNC_MIN);
    localparam logic [10:0] VS_MIN  = 11'(VSYNC_MIN);
    localparam logic [11:0] HSTART  = 12'(H_START);
    localparam logic        HPAR    = 1'(H_START % 2);
    localparam logic [PW-1:0] HPIX  = PW'(H_PIXELS);
    localparam logic [PW-1:0] HLAST = PW'(H_PIXELS - 1);
    localparam logic [8:0]  VFIRST  = 9'(V_START);
    localparam logic [8:0]  VLAST   = 9'(V_START + V_LINES - 1);
    localparam logic [8:0]  YLAST   = 9'(V_LINES - 1);
    localparam logic [13:0] BPL     = 14'(H_PIXELS / 8);
    localparam logic [11:0] TO_LAST = 12'(LINE_TIMEOUT - 1);

    typedef enum logic [1:0] {SEEK, LINES, ACTIVE} state_t;
    state_t state, state_nx;

    logic          sync_r, data_r, sync_q;
    logic [10:0]   low_cnt;
    logic [11:0]   to_cnt;
    logic [11:0]   h_cnt;
    logic [PW-1:0] pix_cnt;
    logic [7:0]    shreg;

    logic       rise, vs_ev, hs_ev, any_ev, tmo_hit;
    logic       sample, byte_full, write, start_line;
    logic [8:0] line_nx, y;
    logic       nx_in_range;

    assign rise    = sync_r & ~sync_q;
    assign vs_ev   = rise && (low_cnt >= VS_MIN);
    assign hs_ev   = rise && (low_cnt >= HS_MIN) && (low_cnt < VS_MIN);
    assign any_ev  = vs_ev | hs_ev;
    assign tmo_hit = (state != SEEK) && (to_cnt == TO_LAST) && !any_ev;

    assign line_nx     = (line_cnt == 9'd511) ? 9'd511 : line_cnt + 9'd1;
    assign nx_in_range = (line_nx >= VFIRST) && (line_nx <= VLAST);
    assign start_line  = (state != SEEK) && hs_ev && nx_in_range;
    assign y           = line_cnt - VFIRST;

    // Sampling pauses while sync is low, so a sync pulse that lands mid-line
    // never completes a byte with blanking-level pixels.
    assign sample    = (state == ACTIVE) && sync_r && (h_cnt >= HSTART) &&
                       (h_cnt[0] == HPAR) && (pix_cnt < HPIX);
    assign byte_full = sample && (pix_cnt[2:0] == 3'd7);
    assign write     = byte_full && !any_ev && !tmo_hit;
    assign locked    = (state != SEEK);

    always_ff @(posedge clk) begin
        if (reset) state <= SEEK;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEEK:   if (vs_ev) state_nx = LINES;
            LINES: begin
                if (vs_ev)           state_nx = LINES;
                else if (start_line) state_nx = ACTIVE;
            end
            ACTIVE: begin
                if (vs_ev)                 state_nx = LINES;
                else if (hs_ev)            state_nx = nx_in_range ? ACTIVE : LINES;
                else if (pix_cnt == HPIX)  state_nx = LINES;
            end
            default: state_nx = SEEK;
        endcase
        if (tmo_hit) state_nx = SEEK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r     <= 1'b0;
            data_r     <= 1'b0;
            sync_q     <= 1'b0;
            low_cnt    <= '0;
            to_cnt     <= '0;
            h_cnt      <= '0;
            pix_cnt    <= '0;
            shreg      <= '0;
            line_cnt   <= '0;
            sync_lost  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            sync_r <= vid_sync;
            data_r <= vid_data;
            sync_q <= sync_r;

            if (sync_r)                 low_cnt <= '0;
            else if (low_cnt != 11'h7FF) low_cnt <= low_cnt + 11'd1;

            if (any_ev)                 to_cnt <= '0;
            else if (to_cnt != 12'hFFF) to_cnt <= to_cnt + 12'd1;

            if (vs_ev)                        line_cnt <= '0;
            else if (hs_ev && state != SEEK)  line_cnt <= line_nx;

            if (vs_ev)        sync_lost <= 1'b0;
            else if (tmo_hit) sync_lost <= 1'b1;

            if (start_line) begin
                h_cnt   <= '0;
                pix_cnt <= '0;
                shreg   <= '0;
            end else begin
                if (state == ACTIVE && h_cnt != 12'hFFF) h_cnt <= h_cnt + 12'd1;
                if (sample) begin
                    pix_cnt <= pix_cnt + PW'(1);
                    shreg   <= {shreg[6:0], data_r};
                end
            end

            wr_en      <= write;
            frame_done <= write && (pix_cnt == HLAST) && (y == YLAST);
            if (write) begin
                wr_data <= {shreg[6:0], data_r};
                wr_addr <= 14'(y) * BPL + 14'(pix_cnt >> 3);
            end
        end
    end

endmodule

// File: doc/nas_vid_capture.md
Name: nas_vid_capture

Overview:
- Downstream consumer of the Nascom 2 video circuit's composite outputs (vid_sync, vid_data), for simulation and FPGA bring-up.
- Separates horizontal and vertical sync by pulse width, recovers line and pixel timing, and samples the 8 MHz pixel stream.
- Packs the visible frame into bytes and emits a byte-wide write stream to an external frame-buffer RAM, so benches can compare captured screens against expected VRAM contents.

Parameters:
- HSYNC_MIN, 32: minimum sync-low width in clk cycles accepted as a line sync; shorter pulses are glitches.
- VSYNC_MIN, 400: minimum sync-low width in clk cycles classed as frame sync; must be greater than HSYNC_MIN.
- H_START, 160: clk cycles from the hsync rising edge to the first pixel sample.
- H_PIXELS, 384: pixels captured per line (48 chars x 8); must be a multiple of 8.
- V_START, 20: line index (after vsync) of the first captured line.
- V_LINES, 224: captured lines (16 rows x 14 scanlines).
- LINE_TIMEOUT, 2048: clk cycles without any valid sync event before lock is declared lost.

Ports:
- clk  in  1  16 MHz video clock, same clock that drives the video circuit.
- reset  in  1  synchronous, active-high reset.
- vid_sync  in  1  composite sync, low = sync pulse.
- vid_data  in  1  video data, 1 = lit pixel.
- wr_en  out  1  one-cycle strobe, frame-buffer byte write.
- wr_addr  out  14  byte address = y*(H_PIXELS/8) + x/8.
- wr_data  out  8  8 packed pixels; first-sampled pixel in bit 7.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is written.
- locked  out  1  1 while tracking frame timing.
- sync_lost  out  1  sticky error flag.
- line_cnt  out  9  lines since last vsync; saturates at 511.

Behaviour:
- Reset values: all outputs 0; state SEEK; every counter and the shift register cleared. Reset asserted mid-frame aborts the frame with no write and no frame_done.
- Input register: vid_sync and vid_data each pass through one flop. All edge detection and sampling use the registered copies.
- Sync classifier: low_cnt (11 bit, saturating) clears when sync is high and increments while it is low. On a sync rising edge (registered value goes 0 to 1), using low_cnt as held on that edge:
  - low_cnt >= VSYNC_MIN: vsync event.
  - HSYNC_MIN <= low_cnt < VSYNC_MIN: hsync event.
  - otherwise: ignored.
- State SEEK: locked=0. A vsync event sets line_cnt=0, locked=1, clears sync_lost, and moves to LINES. Hsync events are ignored.
- State LINES: each hsync event increments line_cnt. If the new line_cnt is in [V_START, V_START+V_LINES-1], go to ACTIVE with h_cnt=0 and pix_cnt=0.
- State ACTIVE: h_cnt increments every clk.
  - When h_cnt >= H_START and (h_cnt-H_START) is even, shift the registered vid_data into an 8-bit shift register (MSB first) and increment pix_cnt.
  - When pix_cnt reaches a multiple of 8, the cycle after the 8th sample drives wr_en=1, wr_data = shift register, wr_addr = (line_cnt-V_START)*(H_PIXELS/8) + (pix_cnt/8 - 1).
  - After H_PIXELS samples, return to LINES.
  - If the captured line was the last (y = V_LINES-1), frame_done pulses in the same cycle as the final wr_en.
- An hsync event during ACTIVE ends the line early: the partial byte is discarded, line_cnt increments, and the LINES range check is re-applied.
- A vsync event in any locked state discards any partial byte, sets line_cnt=0, and moves to LINES. A frame cut short this way produces no frame_done.
- Timeout: a counter clears on every hsync or vsync event. While locked, if it reaches LINE_TIMEOUT: sync_lost=1, locked=0, state goes to SEEK. sync_lost is cleared only by the next vsync event or by reset.
- No wr_en is ever issued outside ACTIVE. wr_addr never exceeds V_LINES*H_PIXELS/8 - 1.

Test Plan:
- Sync classification: sync-low pulses of 20, 75 and 500 clk. Required: 20 ignored; 75 increments line_cnt; 500 resets line_cnt to 0 and sets locked=1.
- Full frame: vsync, then 250 lines of 1024 clk each with 75-clk hsync. Drive vid_data=1 only for pixels 0-7 of line V_START. Required: first write has wr_addr=0, wr_data=0xFF; all other writes have wr_data=0x00; 10752 wr_en pulses in total; one frame_done pulse coincident with wr_addr=10751.
- Bit order: vid_data high for pixel 15 only on captured line 3. Required: write at wr_addr=3*48+1=145 has wr_data=0x01.
- Timeout: after lock, hold sync high for 3000 clk. Required: sync_lost=1 and locked=0 at clk 2048 after the last event, with no wr_en; the next vsync clears sync_lost.
- Mid-line vsync: inject a 500-clk sync pulse after 100 pixels of a captured line. Required: no write for the partial byte 12; line_cnt=0; no frame_done.
- Reset during ACTIVE: assert reset for 1 clk. Required: all outputs 0 on the next cycle, state SEEK, no further writes until a vsync event.
